// File: rtl/serdes_pkg.sv
// Shared definitions for the serial encryptor/decryptor pair: state encoding,
// byte width, default key and the byte cipher primitive.
package serdes_pkg;

  localparam int unsigned BYTE_W = 8;

  localparam logic [127:0] DEFAULT_KEY = 128'h0F1E_2D3C_4B5A_6978_8796_A5B4_C3D2_E134;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_RECV    = 2'd1,
    ST_DECRYPT = 2'd2
  } state_t;

  // Symmetric XOR cipher: the same operation encrypts and decrypts.
  function automatic logic [BYTE_W-1:0] xor_byte(input logic [BYTE_W-1:0] data,
                                                  input logic [BYTE_W-1:0] key_byte);
    return data ^ key_byte;
  endfunction

endpackage

// File: rtl/serdes_byte_fifo2.sv
// Two-entry valid/ready byte FIFO with registered head, full flag and
// push/pop counters. A push while full is accepted only with a same-cycle pop.
module serdes_byte_fifo2
  import serdes_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              i_push,
  input  logic [BYTE_W-1:0] i_data,
  input  logic              i_pop,
  output logic [BYTE_W-1:0] o_data,
  output logic              o_valid,
  output logic              o_full,
  output logic [7:0]        o_push_cnt,
  output logic [7:0]        o_pop_cnt
);

  logic [BYTE_W-1:0] r_mem0;
  logic [BYTE_W-1:0] r_mem1;
  logic [1:0]        r_count;
  logic              r_valid;
  logic              r_full;
  logic [7:0]        r_push_cnt;
  logic [7:0]        r_pop_cnt;

  logic              w_pop;
  logic              w_push;
  logic [1:0]        w_count_nxt;

  assign w_pop  = i_pop & r_valid;
  assign w_push = i_push & (~r_full | w_pop);

  always_comb begin
    w_count_nxt = r_count;
    case ({w_push, w_pop})
      2'b10:   w_count_nxt = r_count + 2'd1;
      2'b01:   w_count_nxt = r_count - 2'd1;
      default: w_count_nxt = r_count;
    endcase
  end

  // Shift-style storage keeps the head in r_mem0 so o_data is a plain register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem0     <= '0;
      r_mem1     <= '0;
      r_count    <= 2'd0;
      r_valid    <= 1'b0;
      r_full     <= 1'b0;
      r_push_cnt <= 8'd0;
      r_pop_cnt  <= 8'd0;
    end else begin
      r_count <= w_count_nxt;
      r_valid <= (w_count_nxt != 2'd0);
      r_full  <= (w_count_nxt == 2'd2);
      if (w_push) r_push_cnt <= r_push_cnt + 8'd1;
      if (w_pop)  r_pop_cnt  <= r_pop_cnt + 8'd1;
      case ({w_push, w_pop})
        2'b11: begin
          if (r_count == 2'd1) begin
            r_mem0 <= i_data;
          end else begin
            r_mem0 <= r_mem1;
            r_mem1 <= i_data;
          end
        end
        2'b10: begin
          if (r_count == 2'd0) r_mem0 <= i_data;
          else                 r_mem1 <= i_data;
        end
        2'b01:   r_mem0 <= r_mem1;
        default: r_mem0 <= r_mem0;
      endcase
    end
  end

  assign o_data     = r_mem0;
  assign o_valid    = r_valid;
  assign o_full     = r_full;
  assign o_push_cnt = r_push_cnt;
  assign o_pop_cnt  = r_pop_cnt;

endmodule

// File: rtl/secure_serdes_decryptor_core.sv
// Receive-side serial decryptor: deserializes MSB-first cipher bytes, XORs with
// a key slice and queues the plaintext in a 2-entry buffer with sticky errors.
module secure_serdes_decryptor_core
  import serdes_pkg::*;
#(
  parameter int unsigned KEY_LSB    = 0,
  parameter int unsigned FIFO_DEPTH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [127:0]      key,
  input  logic              frame_start,
  input  logic              cipher_in,
  output logic [BYTE_W-1:0] m_data,
  output logic              m_valid,
  input  logic              m_ready,
  output logic              busy,
  output logic              err_frame,
  output logic              err_overflow,
  input  logic              clr_err,
  output logic [7:0]        frame_cnt
);

  state_t            r_state;
  logic [BYTE_W-1:0] r_shreg;
  logic [2:0]        r_bit_cnt;
  logic              r_busy;
  logic              r_err_frame;
  logic              r_err_overflow;

  logic              w_push;
  logic              w_pop;
  logic              w_full;
  logic              w_frame_set;
  logic              w_overflow_set;
  logic [BYTE_W-1:0] w_plain;
  logic [7:0]        w_pop_cnt;

  assign w_plain        = xor_byte(r_shreg, key[KEY_LSB +: BYTE_W]);
  assign w_push         = (r_state == ST_DECRYPT);
  assign w_pop          = m_valid & m_ready;
  assign w_frame_set    = (r_state == ST_RECV) & frame_start;
  assign w_overflow_set = w_push & w_full & ~w_pop;

  // Receive FSM; a new error event wins over a same-cycle clear.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state        <= ST_IDLE;
      r_shreg        <= '0;
      r_bit_cnt      <= 3'd0;
      r_busy         <= 1'b0;
      r_err_frame    <= 1'b0;
      r_err_overflow <= 1'b0;
    end else begin
      r_err_frame    <= w_frame_set | (r_err_frame & ~clr_err);
      r_err_overflow <= w_overflow_set | (r_err_overflow & ~clr_err);
      case (r_state)
        ST_IDLE, ST_DECRYPT: begin
          if (frame_start) begin
            r_shreg   <= {7'b0, cipher_in};
            r_bit_cnt <= 3'd1;
            r_state   <= ST_RECV;
            r_busy    <= 1'b1;
          end else begin
            r_state <= ST_IDLE;
            r_busy  <= 1'b0;
          end
        end
        ST_RECV: begin
          r_busy <= 1'b1;
          if (frame_start) begin
            r_shreg   <= {7'b0, cipher_in};
            r_bit_cnt <= 3'd1;
            r_state   <= ST_RECV;
          end else begin
            r_shreg   <= {r_shreg[6:0], cipher_in};
            r_bit_cnt <= r_bit_cnt + 3'd1;
            if (r_bit_cnt == 3'd7) r_state <= ST_DECRYPT;
            else                   r_state <= ST_RECV;
          end
        end
        default: begin
          r_state <= ST_IDLE;
          r_busy  <= 1'b0;
        end
      endcase
    end
  end

  serdes_byte_fifo2 u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (w_plain),
    .i_pop      (m_ready),
    .o_data     (m_data),
    .o_valid    (m_valid),
    .o_full     (w_full),
    .o_push_cnt (frame_cnt),
    .o_pop_cnt  (w_pop_cnt)
  );

  assign busy         = r_busy;
  assign err_frame    = r_err_frame;
  assign err_overflow = r_err_overflow;

endmodule
